// File: rtl/alu_steuerwerk.sv
`default_nettype none
// ============================================================================
//  Module      : alu_steuerwerk
//  Description : Sequencer between instruction decode and the ALU. Accepts one
//                operation per valid/ready handshake, latches operands and
//                function code, issues StartSignal then Schreibsignal, waits
//                on multi-cycle units (sqrt/div/mod) with a timeout, and
//                returns the captured result over a second valid/ready
//                handshake. Unsupported codes are answered with an error
//                result and never reach the ALU strobes.
//  Ports       :
//      Clock_i / Reset_i            clock, synchronous active-high reset
//      Anfrage_i / Bereit_o         request handshake
//      AnfrageCode_i, AnfrageDaten1_i, AnfrageDaten2_i   request payload
//      Daten1_o, Daten2_o, FunktionsCode_o               latched to the ALU
//      StartSignal_o, Schreibsignal_o                    one-cycle ALU strobes
//      AluErgebnis_i, MehrzyklusFertig_i                 ALU result / done
//      Ergebnis_o, Fehler_o, ErgebnisGueltig_o, ErgebnisAbnahme_i
//                                                        result handshake
//  Parameter   : ZEITLIMIT (1..255) cycles allowed in WARTEN before timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_steuerwerk #(
    parameter int unsigned ZEITLIMIT = 64
) (
    input  logic        Clock_i,
    input  logic        Reset_i,
    input  logic        Anfrage_i,
    output logic        Bereit_o,
    input  logic [5:0]  AnfrageCode_i,
    input  logic [31:0] AnfrageDaten1_i,
    input  logic [31:0] AnfrageDaten2_i,
    output logic [31:0] Daten1_o,
    output logic [31:0] Daten2_o,
    output logic [5:0]  FunktionsCode_o,
    output logic        StartSignal_o,
    output logic        Schreibsignal_o,
    input  logic [31:0] AluErgebnis_i,
    input  logic        MehrzyklusFertig_i,
    output logic [31:0] Ergebnis_o,
    output logic        ErgebnisGueltig_o,
    input  logic        ErgebnisAbnahme_i,
    output logic        Fehler_o
);

    typedef enum logic [2:0] {
        LEERLAUF  = 3'd0,
        START     = 3'd1,
        SCHREIBEN = 3'd2,
        WARTEN    = 3'd3,
        ERFASSEN  = 3'd4,
        AUSGABE   = 3'd5
    } state_e;

    // Counter value at which WARTEN gives up (compared against the
    // incremented count, so the error result appears ZEITLIMIT cycles
    // after the start strobe).
    localparam logic [8:0] LIMIT_M1 = 9'(ZEITLIMIT - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [8:0]  cnt_d;
    logic        bereit_q;
    logic        start_q;
    logic        schreib_q;
    logic        gueltig_q;
    logic        fehler_q;
    logic [31:0] ergebnis_q;
    logic [31:0] daten1_q;
    logic [31:0] daten2_q;
    logic [5:0]  code_q;
    logic        w_req_supported;
    logic        w_is_multi;

    function automatic logic f_supported(input logic [5:0] code);
        logic [4:0] lo;
        lo = code[4:0];
        return !code[5] && ((lo <= 5'd9) ||
                            ((lo >= 5'd16) && (lo <= 5'd21)) ||
                            ((lo >= 5'd24) && (lo <= 5'd28)));
    endfunction

    // The request is decoded from the input bus; the multi-cycle decision is
    // taken in START from the already latched code.
    assign w_req_supported = f_supported(AnfrageCode_i);
    assign w_is_multi      = (code_q == 6'd3) || (code_q == 6'd4) ||
                             (code_q == 6'd5);
    assign cnt_d           = {1'b0, cnt_q} + 9'd1;

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q    <= LEERLAUF;
            cnt_q      <= 8'd0;
            bereit_q   <= 1'b1;
            start_q    <= 1'b0;
            schreib_q  <= 1'b0;
            gueltig_q  <= 1'b0;
            fehler_q   <= 1'b0;
            ergebnis_q <= 32'd0;
            daten1_q   <= 32'd0;
            daten2_q   <= 32'd0;
            code_q     <= 6'd0;
        end else begin
            // Strobes are single-cycle; only the transitions below raise them.
            start_q   <= 1'b0;
            schreib_q <= 1'b0;
            case (state_q)
                LEERLAUF: begin
                    if (Anfrage_i && bereit_q) begin
                        daten1_q <= AnfrageDaten1_i;
                        daten2_q <= AnfrageDaten2_i;
                        code_q   <= AnfrageCode_i;
                        bereit_q <= 1'b0;
                        if (w_req_supported) begin
                            start_q <= 1'b1;
                            state_q <= START;
                        end else begin
                            ergebnis_q <= 32'd0;
                            fehler_q   <= 1'b1;
                            gueltig_q  <= 1'b1;
                            state_q    <= AUSGABE;
                        end
                    end
                end
                START: begin
                    cnt_q <= 8'd0;
                    if (w_is_multi) begin
                        state_q <= WARTEN;
                    end else begin
                        schreib_q <= 1'b1;
                        state_q   <= SCHREIBEN;
                    end
                end
                WARTEN: begin
                    cnt_q <= cnt_d[7:0];
                    // Done has priority over a timeout on the same edge.
                    if (MehrzyklusFertig_i) begin
                        schreib_q <= 1'b1;
                        state_q   <= SCHREIBEN;
                    end else if (cnt_d >= LIMIT_M1) begin
                        ergebnis_q <= 32'd0;
                        fehler_q   <= 1'b1;
                        gueltig_q  <= 1'b1;
                        state_q    <= AUSGABE;
                    end
                end
                SCHREIBEN: begin
                    state_q <= ERFASSEN;
                end
                ERFASSEN: begin
                    ergebnis_q <= AluErgebnis_i;
                    fehler_q   <= 1'b0;
                    gueltig_q  <= 1'b1;
                    state_q    <= AUSGABE;
                end
                AUSGABE: begin
                    if (ErgebnisAbnahme_i) begin
                        gueltig_q <= 1'b0;
                        bereit_q  <= 1'b1;
                        state_q   <= LEERLAUF;
                    end
                end
                default: begin
                    gueltig_q <= 1'b0;
                    bereit_q  <= 1'b1;
                    state_q   <= LEERLAUF;
                end
            endcase
        end
    end

    assign Bereit_o          = bereit_q;
    assign StartSignal_o     = start_q;
    assign Schreibsignal_o   = schreib_q;
    assign ErgebnisGueltig_o = gueltig_q;
    assign Fehler_o          = fehler_q;
    assign Ergebnis_o        = ergebnis_q;
    assign Daten1_o          = daten1_q;
    assign Daten2_o          = daten2_q;
    assign FunktionsCode_o   = code_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_steuerwerk.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_steuerwerk
//  Description : Self-checking bench for alu_steuerwerk. A per-operation
//                timeline model fills per-cycle expectation tables, a single
//                compare process checks every DUT output each cycle, and a
//                few literal values pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_steuerwerk;

    localparam int Z   = 8;
    localparam int N   = 100;
    localparam int END = 90;

    logic        clk;
    logic        rst;
    logic        Anfrage, Bereit, StartSignal, Schreibsignal;
    logic        MehrzyklusFertig, ErgebnisGueltig, ErgebnisAbnahme, Fehler;
    logic [5:0]  AnfrageCode, FunktionsCode;
    logic [31:0] AnfrageDaten1, AnfrageDaten2, Daten1, Daten2;
    logic [31:0] AluErgebnis, Ergebnis;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Stimulus per cycle (driven during cycle c, sampled on edge c+1)
    bit          s_rst [N];
    bit          s_anf [N];
    bit          s_fert[N];
    bit          s_abn [N];
    logic [5:0]  s_code[N];
    logic [31:0] s_d1  [N];
    logic [31:0] s_d2  [N];

    // Expected outputs per cycle
    bit          e_bereit[N];
    bit          e_start [N];
    bit          e_write [N];
    bit          e_valid [N];
    bit          e_zero  [N];
    bit          e_fehl  [N];
    logic [31:0] e_res   [N];
    logic [31:0] e_d1    [N];
    logic [31:0] e_d2    [N];
    logic [5:0]  e_code  [N];

    alu_steuerwerk #(.ZEITLIMIT(Z)) dut (
        .Clock_i           (clk),
        .Reset_i           (rst),
        .Anfrage_i         (Anfrage),
        .Bereit_o          (Bereit),
        .AnfrageCode_i     (AnfrageCode),
        .AnfrageDaten1_i   (AnfrageDaten1),
        .AnfrageDaten2_i   (AnfrageDaten2),
        .Daten1_o          (Daten1),
        .Daten2_o          (Daten2),
        .FunktionsCode_o   (FunktionsCode),
        .StartSignal_o     (StartSignal),
        .Schreibsignal_o   (Schreibsignal),
        .AluErgebnis_i     (AluErgebnis),
        .MehrzyklusFertig_i(MehrzyklusFertig),
        .Ergebnis_o        (Ergebnis),
        .ErgebnisGueltig_o (ErgebnisGueltig),
        .ErgebnisAbnahme_i (ErgebnisAbnahme),
        .Fehler_o          (Fehler)
    );

    // Simple ALU stand-in; also used by the model for expected results.
    function automatic logic [31:0] alu_fn(input logic [5:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        case (c)
            6'd0:    return a + b;
            6'd1:    return a - b;
            6'd4:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            6'd5:    return (b == 32'd0) ? a : a % b;
            default: return a ^ b ^ {26'd0, c};
        endcase
    endfunction

    assign AluErgebnis = alu_fn(FunktionsCode, Daten1, Daten2);

    function automatic bit m_supported(input logic [5:0] c);
        int v;
        v = int'(c);
        return (v <= 9) || (v >= 16 && v <= 21) || (v >= 24 && v <= 28);
    endfunction

    // Timeline model of one operation accepted on edge A.
    // k: cycles after start until done is sampled (0 = never).
    // hold: extra cycles the result waits before being taken (0 = taken at once,
    //       with ErgebnisAbnahme held high across the whole operation).
    task automatic plan(input int A, input logic [5:0] code, input logic [31:0] d1,
                        input logic [31:0] d2, input int k, input int hold);
        int vs, wc;
        bit sup, mul, f;
        logic [31:0] r;
        sup = m_supported(code);
        mul = (code == 6'd3) || (code == 6'd4) || (code == 6'd5);
        s_anf[A-1]  = 1'b1;
        s_code[A-1] = code;
        s_d1[A-1]   = d1;
        s_d2[A-1]   = d2;
        if (!sup) begin
            wc = -1; vs = A; r = 32'd0; f = 1'b1;
        end else if (!mul) begin
            wc = A + 1; vs = A + 3; r = alu_fn(code, d1, d2); f = 1'b0;
        end else if (k >= 1 && k <= Z - 1) begin
            s_fert[A+k] = 1'b1;
            wc = A + 1 + k; vs = A + 3 + k; r = alu_fn(code, d1, d2); f = 1'b0;
        end else begin
            wc = -1; vs = A + Z; r = 32'd0; f = 1'b1;
        end
        if (sup) e_start[A] = 1'b1;
        if (wc >= 0) e_write[wc] = 1'b1;
        if (hold == 0) begin
            for (int c = A - 1; c <= vs; c++) s_abn[c] = 1'b1;
        end else begin
            s_abn[vs+hold] = 1'b1;
        end
        for (int c = A; c <= vs + hold; c++) e_bereit[c] = 1'b0;
        for (int c = vs; c <= vs + hold; c++) begin
            e_valid[c] = 1'b1;
            e_res[c]   = r;
            e_fehl[c]  = f;
        end
        for (int c = A; c < N; c++) begin
            e_d1[c] = d1; e_d2[c] = d2; e_code[c] = code;
        end
    endtask

    // Reset sampled on edge R: everything from cycle R on returns to idle.
    task automatic apply_reset(input int R);
        s_rst[R-1] = 1'b1;
        for (int c = R; c < N; c++) begin
            e_bereit[c] = 1'b1; e_start[c] = 1'b0; e_write[c] = 1'b0;
            e_valid[c]  = 1'b0; e_d1[c] = 32'd0; e_d2[c] = 32'd0; e_code[c] = 6'd0;
            s_abn[c]    = 1'b0; s_fert[c] = 1'b0;
        end
        e_zero[R] = 1'b1; e_res[R] = 32'd0; e_fehl[R] = 1'b0;
    endtask

    task automatic drive(input int c);
        rst              = s_rst[c];
        Anfrage          = s_anf[c];
        AnfrageCode      = s_anf[c] ? s_code[c] : 6'($urandom);
        AnfrageDaten1    = s_anf[c] ? s_d1[c] : $urandom;
        AnfrageDaten2    = s_anf[c] ? s_d2[c] : $urandom;
        MehrzyklusFertig = s_fert[c];
        ErgebnisAbnahme  = s_abn[c];
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every output, every cycle, plus literal pins.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc <= END) begin
            chk("Bereit",          32'(Bereit),          32'(e_bereit[cyc]));
            chk("StartSignal",     32'(StartSignal),     32'(e_start[cyc]));
            chk("Schreibsignal",   32'(Schreibsignal),   32'(e_write[cyc]));
            chk("ErgebnisGueltig", 32'(ErgebnisGueltig), 32'(e_valid[cyc]));
            chk("Daten1",          Daten1,               e_d1[cyc]);
            chk("Daten2",          Daten2,               e_d2[cyc]);
            chk("FunktionsCode",   32'(FunktionsCode),   32'(e_code[cyc]));
            if (e_valid[cyc] || e_zero[cyc]) begin
                chk("Ergebnis", Ergebnis,     e_res[cyc]);
                chk("Fehler",   32'(Fehler),  32'(e_fehl[cyc]));
            end
            case (cyc)
                6:  chk("pin_start_add",   32'(StartSignal),     32'd1);
                7:  chk("pin_write_add",   32'(Schreibsignal),   32'd1);
                9:  begin
                        chk("pin_valid_add", 32'(ErgebnisGueltig), 32'd1);
                        chk("pin_res_add",   Ergebnis,             32'd12);
                    end
                20: chk("pin_res_div",     Ergebnis,             32'd14);
                31: chk("pin_no_valid_to", 32'(ErgebnisGueltig), 32'd0);
                32: begin
                        chk("pin_fehl_to",   32'(Fehler),          32'd1);
                        chk("pin_res_to",    Ergebnis,             32'd0);
                    end
                35: chk("pin_fehl_unsup",  32'(Fehler),          32'd1);
                48: chk("pin_write_tie",   32'(Schreibsignal),   32'd1);
                50: chk("pin_fehl_tie",    32'(Fehler),          32'd0);
                58: chk("pin_rst_bereit",  32'(Bereit),          32'd1);
                64: chk("pin_b2b_1",       Ergebnis,             32'd3);
                69: chk("pin_b2b_2",       Ergebnis,             32'd7);
                74: chk("pin_b2b_3",       Ergebnis,             32'd30);
                default: ;
            endcase
        end
    end

    initial begin
        for (int c = 0; c < N; c++) begin
            e_bereit[c] = 1'b1;
            e_res[c] = 32'd0; e_d1[c] = 32'd0; e_d2[c] = 32'd0; e_code[c] = 6'd0;
            s_code[c] = 6'd0; s_d1[c] = 32'd0; s_d2[c] = 32'd0;
        end
        for (int c = 0; c < 3; c++) s_rst[c] = 1'b1;
        for (int c = 1; c <= 3; c++) e_zero[c] = 1'b1;

        plan(6,  6'd0,        32'd5,   32'd7,  0, 0);  // add 5+7
        s_fert[8] = 1'b1;                              // done outside WARTEN
        plan(12, 6'd4,        32'd100, 32'd7,  5, 2);  // div, result held
        for (int c = 20; c <= 22; c++) begin           // request during AUSGABE
            s_anf[c] = 1'b1; s_code[c] = 6'd3; s_d1[c] = 32'd9; s_d2[c] = 32'd0;
        end
        plan(24, 6'd3,        32'd9,   32'd0,  0, 0);  // sqrt, timeout
        plan(35, 6'b100000,   32'd1,   32'd2,  0, 0);  // bit 5 set
        plan(37, 6'b001100,   32'd3,   32'd4,  0, 0);  // gap code
        plan(40, 6'd5,        32'd50,  32'd7,  7, 0);  // done on timeout edge
        plan(53, 6'd4,        32'd8,   32'd2,  0, 0);  // interrupted by reset
        apply_reset(58);
        plan(61, 6'd0,        32'd1,   32'd2,  0, 0);  // back-to-back adds
        plan(66, 6'd0,        32'd3,   32'd4,  0, 0);
        plan(71, 6'd0,        32'd10,  32'd20, 0, 0);
        plan(77, 6'b011100,   32'd3,   32'd5,  0, 0);  // highest supported code
        plan(83, 6'b010110,   32'd6,   32'd7,  0, 0);  // unsupported 10110

        drive(0);
        while (cyc < END) begin
            @(negedge clk);
            drive(cyc);
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
